// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy engine.
// Optional descending (memmove) mode is enabled by defining MEM_COPY_OVERLAP_EN.
package mem_copy_pkg;

    localparam int DEF_AWIDTH = 16;
    localparam int DEF_DWIDTH = 16;
    localparam int DEF_LWIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Loadable up/down address counter; one instance each for read and write pointers.
// Arithmetic wraps modulo 2^AWIDTH.
module mem_copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [AWIDTH-1:0] i_load_val,
    input  logic              i_step,
    input  dir_t              i_dir,
    output logic [AWIDTH-1:0] o_addr
);

    localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

    logic [AWIDTH-1:0] r_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_step) begin
            r_addr <= (i_dir == DIR_DOWN) ? (r_addr - ONE) : (r_addr + ONE);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/mem_copy_engine.sv
// Streams len words from src to dst through a dual-port memory, one word per cycle.
// Define MEM_COPY_OVERLAP_EN to copy descending when dst > src (memmove semantics).
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int LWIDTH = DEF_LWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] src,
    input  logic [AWIDTH-1:0] dst,
    input  logic [LWIDTH-1:0] len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LWIDTH-1:0] count,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata
);

    localparam logic [LWIDTH-1:0] LEN_ONE = LWIDTH'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [LWIDTH-1:0] r_remaining;
    logic [LWIDTH-1:0] r_count;
    logic              r_valid;
    logic              r_aborted;
    logic              w_accept;
    logic              w_issue;
    logic [AWIDTH-1:0] w_rload;
    logic [AWIDTH-1:0] w_wload;
    logic [AWIDTH-1:0] w_raddr;
    logic [AWIDTH-1:0] w_waddr;
    dir_t              w_dir;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_issue  = (r_state == ST_RUN) && !abort;

`ifdef MEM_COPY_OVERLAP_EN
    logic              w_desc;
    logic [LWIDTH-1:0] w_len_m1;
    logic [AWIDTH-1:0] w_last_off;
    dir_t              r_dir;

    // Copying from the top end down keeps source words intact until they are read.
    assign w_desc     = (dst > src);
    assign w_len_m1   = len - LEN_ONE;
    assign w_last_off = AWIDTH'(w_len_m1);
    assign w_rload    = w_desc ? (src + w_last_off) : src;
    assign w_wload    = w_desc ? (dst + w_last_off) : dst;
    assign w_dir      = r_dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir <= DIR_UP;
        end else if (w_accept) begin
            r_dir <= w_desc ? DIR_DOWN : DIR_UP;
        end
    end
`else
    assign w_rload = src;
    assign w_wload = dst;
    assign w_dir   = DIR_UP;
`endif

    mem_copy_addr_gen #(.AWIDTH(AWIDTH)) u_rptr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (w_rload),
        .i_step     (w_issue),
        .i_dir      (w_dir),
        .o_addr     (w_raddr)
    );

    mem_copy_addr_gen #(.AWIDTH(AWIDTH)) u_wptr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (w_wload),
        .i_step     (r_valid),
        .i_dir      (w_dir),
        .o_addr     (w_waddr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Write valid trails each issued read by the memory's one-cycle latency.
            r_valid <= w_issue;
            if (w_accept) begin
                r_remaining <= len;
                r_count     <= '0;
                r_aborted   <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_remaining <= r_remaining - LEN_ONE;
                end
                if (r_valid) begin
                    r_count <= r_count + LEN_ONE;
                end
                if ((r_state == ST_RUN) && abort) begin
                    r_aborted <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        aborted      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort || (r_remaining == LEN_ONE)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy         = 1'b1;
                w_state_next = ST_FIN;
            end
            ST_FIN: begin
                done         = 1'b1;
                aborted      = r_aborted;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign count     = r_count;
    assign mem_re    = w_issue;
    assign mem_raddr = w_raddr;
    assign mem_we    = r_valid;
    assign mem_waddr = w_waddr;
    assign mem_wdata = mem_rdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural dual-port memory model.
// Overlap checks apply only when MEM_COPY_OVERLAP_EN is defined.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [15:0] src, dst, len;
    logic        busy, done, aborted;
    logic [15:0] count;
    logic        mem_re, mem_we;
    logic [15:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;

    logic [15:0] mem [0:65535];
    logic        p_we;
    logic [15:0] p_addr, p_data;

    int tests = 0;
    int fails = 0;

    logic [15:0] rd_q[$];
    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          done_cyc;
    logic [15:0] done_count;
    logic        done_ab;
    int          busy_bad;

    always #5 clk = ~clk;

    // Registered read returning old data on a same-address collision.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (p_we)   mem[p_addr] <= p_data;
    end

    mem_copy_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .count     (count),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        p_we = 1'b1; p_addr = a; p_data = d;
        @(posedge clk); #1;
        p_we = 1'b0;
    endtask

    // Cycle 0 is the cycle in which start is presented; cycle k is sampled mid-cycle.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input int ab_cyc, input int sb_cyc);
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cyc = -1; busy_bad = 0; done_count = '0; done_ab = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; src = s; dst = d; len = l;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            start = (k == sb_cyc);
            abort = (k == ab_cyc);
            if (k == sb_cyc) begin
                src = 16'h0BAD; dst = 16'h0BAD; len = 16'd2;
            end
            @(negedge clk);
            if (mem_re) rd_q.push_back(mem_raddr);
            if (mem_we) begin
                wa_q.push_back(mem_waddr);
                wd_q.push_back(mem_wdata);
            end
            if (done) begin
                done_cyc   = k;
                done_count = count;
                done_ab    = aborted;
                if (busy || mem_re || mem_we) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        src = '0; dst = '0; len = '0;
        p_we = 1'b0; p_addr = '0; p_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_count", count, 0);
        rst = 1'b1;

        // Basic 4-word copy
        for (int i = 0; i < 4; i++) preload(16'h0100 + 16'(i), 16'hA0A0 + 16'(i));
        run_copy(16'h0100, 16'h0200, 16'd4, 0, 0);
        chk("basic_done_cyc", done_cyc, 6);
        chk("basic_count", done_count, 4);
        chk("basic_aborted", done_ab, 0);
        chk("basic_busy_profile", busy_bad, 0);
        chk("basic_nreads", rd_q.size(), 4);
        chk("basic_nwrites", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_mem%0d", i), mem[16'h0200 + 16'(i)], 16'hA0A0 + 16'(i));

        // Zero length
        run_copy(16'h0100, 16'h0300, 16'd0, 0, 0);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_count", done_count, 0);
        chk("zero_nreads", rd_q.size(), 0);
        chk("zero_nwrites", wa_q.size(), 0);

        // Source wrap past the top of the address space
        preload(16'hFFFE, 16'h1111);
        preload(16'hFFFF, 16'h2222);
        preload(16'h0000, 16'h3333);
        preload(16'h0001, 16'h4444);
        run_copy(16'hFFFE, 16'h0010, 16'd4, 0, 0);
        chk("wrap_nreads", rd_q.size(), 4);
        chk("wrap_nwrites", wa_q.size(), 4);
        if (rd_q.size() == 4 && wa_q.size() == 4) begin
            chk("wrap_raddr0", rd_q[0], 16'hFFFE);
            chk("wrap_raddr1", rd_q[1], 16'hFFFF);
            chk("wrap_raddr2", rd_q[2], 16'h0000);
            chk("wrap_raddr3", rd_q[3], 16'h0001);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("wrap_waddr%0d", i), wa_q[i], 16'h0010 + 16'(i));
                chk($sformatf("wrap_wdata%0d", i), wd_q[i], 16'h1111 * 16'(i + 1));
            end
        end
        chk("wrap_count", done_count, 4);

        // Abort at cycle 4 with a start pulse while busy at cycle 2
        for (int i = 0; i < 8; i++) preload(16'h0300 + 16'(i), 16'h5000 + 16'(i));
        preload(16'h0403, 16'hDEAD);
        run_copy(16'h0300, 16'h0400, 16'd8, 4, 2);
        chk("abort_done_cyc", done_cyc, 6);
        chk("abort_aborted", done_ab, 1);
        chk("abort_count", done_count, 3);
        chk("abort_nreads", rd_q.size(), 3);
        chk("abort_nwrites", wa_q.size(), 3);
        if (wa_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("abort_waddr%0d", i), wa_q[i], 16'h0400 + 16'(i));
        end
        chk("abort_mem402", mem[16'h0402], 16'h5002);
        chk("abort_mem403_untouched", mem[16'h0403], 16'hDEAD);
        @(negedge clk);
        chk("abort_idle_after", busy, 0);

        // Overlapping move with dst > src
        for (int i = 0; i < 4; i++) preload(16'h0020 + 16'(i), 16'(i + 1));
        run_copy(16'h0020, 16'h0022, 16'd4, 0, 0);
        chk("ovl_done_cyc", done_cyc, 6);
        chk("ovl_count", done_count, 4);
`ifdef MEM_COPY_OVERLAP_EN
        for (int i = 0; i < 4; i++) chk($sformatf("ovl_mem%0d", i), mem[16'h0022 + 16'(i)], 16'(i + 1));
        if (rd_q.size() == 4) chk("ovl_first_raddr", rd_q[0], 16'h0023);
`endif

        // Reset mid-transfer, then a fresh copy
        for (int i = 0; i < 16; i++) preload(16'h0500 + 16'(i), 16'(3 * i + 1));
        @(posedge clk); #1;
        start = 1'b1; src = 16'h0500; dst = 16'h0600; len = 16'd16;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_re", mem_re, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_count", count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_copy(16'h0500, 16'h0600, 16'd16, 0, 0);
        chk("post_rst_done_cyc", done_cyc, 18);
        chk("post_rst_count", done_count, 16);
        chk("post_rst_busy_profile", busy_bad, 0);
        chk("post_rst_mem0", mem[16'h0600], 16'd1);
        chk("post_rst_mem15", mem[16'h060F], 16'd46);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator/master for the single-clock dual-port memory: drives its read port (re/raddr, registered rdata, 1-cycle latency) and write port (we/waddr/wdata).
- Copies `len` words from `src` to `dst` at one word per cycle, streaming read data straight into the write port.
- Sits between a control/CPU-side register interface and the memory instance.
- Used for block moves, program-image relocation and buffer copies.

Parameters:
- AWIDTH, 16, address width; must match the memory instance.
- DWIDTH, 16, data width; must match the memory instance.
- LWIDTH, 16, transfer-length width in words.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- start  in  1  request a copy; sampled only when busy=0.
- src  in  AWIDTH  source base address, captured on accepted start.
- dst  in  AWIDTH  destination base address, captured on accepted start.
- len  in  LWIDTH  word count, captured on accepted start.
- abort  in  1  stop issuing reads; in-flight write still completes.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion or abort.
- aborted  out  1  valid with done; 1 if terminated by abort.
- count  out  LWIDTH  words written in current/last transfer.
- mem_re  out  1  to memory re.
- mem_raddr  out  AWIDTH  to memory raddr.
- mem_rdata  in  DWIDTH  from memory rdata (registered, 1-cycle latency).
- mem_we  out  1  to memory we.
- mem_waddr  out  AWIDTH  to memory waddr.
- mem_wdata  out  DWIDTH  to memory wdata; equals mem_rdata combinationally.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - busy, done, aborted, mem_re, mem_we all 0.
  - count=0; all address registers 0.
  - Mid-transfer reset leaves memory partially copied; no recovery.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 captures src/dst/len and clears count.
  - len=0: go to FIN, no memory access.
  - Otherwise go to RUN.
- RUN (read issue):
  - mem_re=1, mem_raddr=rptr; rptr steps 1, remaining decrements.
  - After the read with remaining==1, go to DRAIN.
- Write side:
  - A registered valid flag follows each issued read by one cycle.
  - When valid: mem_we=1, mem_waddr=wptr, mem_wdata=mem_rdata; wptr steps 1, count increments.
  - Writes overlap with reads in RUN.
- DRAIN: no read; last write completes; go to FIN.
- FIN:
  - done=1 for exactly one cycle, busy=0; go to IDLE.
  - start in FIN is ignored.
- Timing for len=N≥1, start accepted at cycle 0:
  - Reads in cycles 1..N; writes in cycles 2..N+1.
  - busy=1 in cycles 1..N+1; done in cycle N+2.
- Address arithmetic is modulo 2^AWIDTH; wrap past max address is legal and silent.
- abort=1 in RUN:
  - Current cycle issues no read; go to DRAIN.
  - The in-flight write (if any) completes; done with aborted=1.
  - abort is ignored in IDLE, DRAIN and FIN.
- start while busy=1 is ignored; no queuing.
- Overlap:
  - Ascending copy is always correct when dst<=src or the regions are disjoint.
  - dst==src+1 is also correct, because the memory returns old data on a same-cycle read/write collision.
  - Other overlaps with dst>src are undefined unless the optional feature is enabled.
- mem_re and mem_we never assert in IDLE or FIN.

Optional Feature:
- MEM_COPY_OVERLAP_EN
- Defined:
  - If dst>src, the copy runs descending: rptr=src+len-1, wptr=dst+len-1, both step -1.
  - The result is correct memmove semantics for any overlap. Latency is unchanged.
- Undefined: always ascending; descending logic is absent.

Decomposition:
- Package mem_copy_pkg:
  - state enum (IDLE, RUN, DRAIN, FIN).
  - Default AWIDTH/DWIDTH/LWIDTH localparams.
  - Step-direction typedef.
- Sub-module mem_copy_addr_gen:
  - Loadable AWIDTH up/down address counter.
  - Inputs: load value, step enable, direction.
  - Instantiated twice (rptr, wptr).

Test Plan:
- Preload mem[0x100..0x103]=A0,A1,A2,A3; start src=0x100, dst=0x200, len=4.
  - Expect mem[0x200..0x203]=A0..A3.
  - Expect done at cycle 6, count=4, aborted=0.
- Start with len=0.
  - Expect no mem_re/mem_we ever.
  - Expect done at cycle 1, count=0.
- Wrap: src=0xFFFE, dst=0x0010, len=4.
  - Expect reads of 0xFFFE,0xFFFF,0x0000,0x0001.
  - Expect writes to 0x0010..0x0013 with matching data.
- Abort: len=8; assert abort at cycle 4.
  - Expect exactly 3 writes, then done with aborted=1, count=3.
  - Also pulse start while busy: expect it ignored.
- Overlap: src=0x20, dst=0x22, len=4, mem[0x20..0x23]=1,2,3,4.
  - With MEM_COPY_OVERLAP_EN: mem[0x22..0x25]=1,2,3,4.
  - Without it: no check (undefined).
- Reset: drop rst mid-RUN of a len=16 copy.
  - Expect busy/mem_we/mem_re=0 immediately.
  - Expect a fresh copy after release to complete correctly.
